// File: rtl/turbo_pkt_dispatch.sv
// Ready-aware round-robin packet dispatcher: fans fixed-length bus packets out
// to NUM_CH decoder lanes, locking one lane for the whole packet.
module turbo_pkt_dispatch #(
    parameter int BUS     = 534,
    parameter int NUM_CH  = 4,
    parameter int PKT_LEN = 25,
    parameter int CH_W    = 4,
    parameter int CNT_W   = 9
) (
    input  logic              clk_bus,
    input  logic              rst,
    input  logic [BUS-1:0]    bus_data,
    input  logic              bus_en,
    output logic              bus_ready,
    input  logic [NUM_CH-1:0] ch_mask,
    input  logic [NUM_CH-1:0] ch_ready,
    output logic [BUS-1:0]    ch_data,
    output logic [NUM_CH-1:0] ch_en,
    output logic [CH_W-1:0]   cur_ch,
    output logic              busy,
    output logic [NUM_CH-1:0] pkt_done,
    output logic              err_drop
);

    // Handshake: bus_ready is a registered hint; any bus_en while LOCKED is a
    // word transfer (lane FIFOs absorb the one-cycle skew), bus_en while IDLE
    // is a dropped word that sets err_drop. busy mirrors the FSM state.
    typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [CH_W-1:0]    ptr, ptr_nxt;
    logic [CH_W-1:0]    cur_nxt, sel, off;
    logic [CH_W:0]      sum;
    logic [NUM_CH-1:0]  avail, rot, cur_oh;
    logic [NUM_CH-1:0]  en_nxt, done_nxt;
    logic [BUS-1:0]     data_nxt;
    logic               found, cur_rdy, last, ready_nxt, err_nxt;

    assign avail   = ch_mask & ch_ready;
    assign cur_rdy = |(cur_oh & ch_ready);
    assign last    = (state == LOCKED) && bus_en && (cnt == CNT_W'(PKT_LEN - 1));
    assign busy    = (state == LOCKED);

    // Rotate availability so bit 0 is the pointer lane, then take the lowest hit.
    always_comb begin
        rot   = NUM_CH'({avail, avail} >> ptr);
        found = 1'b0;
        off   = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (rot[i]) begin
                found = 1'b1;
                off   = CH_W'(i);
            end
        end
        sum = {1'b0, ptr} + {1'b0, off};
        if (sum >= (CH_W + 1)'(NUM_CH)) sum = sum - (CH_W + 1)'(NUM_CH);
        sel = sum[CH_W-1:0];
    end

    always_comb begin
        cur_oh = '0;
        for (int i = 0; i < NUM_CH; i++) cur_oh[i] = (cur_ch == CH_W'(i));
    end

    always_ff @(posedge clk_bus) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            ptr       <= '0;
            bus_ready <= 1'b0;
            ch_data   <= '0;
            ch_en     <= '0;
            cur_ch    <= '0;
            pkt_done  <= '0;
            err_drop  <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            ptr       <= ptr_nxt;
            bus_ready <= ready_nxt;
            ch_data   <= data_nxt;
            ch_en     <= en_nxt;
            cur_ch    <= cur_nxt;
            pkt_done  <= done_nxt;
            err_drop  <= err_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (found) state_nxt = LOCKED;
            LOCKED:  if (last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ready_nxt = 1'b0;
        data_nxt  = ch_data;
        en_nxt    = '0;
        done_nxt  = '0;
        cur_nxt   = cur_ch;
        cnt_nxt   = cnt;
        ptr_nxt   = ptr;
        err_nxt   = err_drop;
        if (state == IDLE) begin
            err_nxt = err_drop | bus_en;
            if (found) begin
                cur_nxt   = sel;
                ready_nxt = 1'b1;
                cnt_nxt   = '0;
            end
        end else begin
            ready_nxt = cur_rdy & ~last;
            if (bus_en) begin
                data_nxt = bus_data;
                en_nxt   = cur_oh;
                cnt_nxt  = last ? '0 : cnt + 1'b1;
            end
            // Next packet search starts just after the lane that finished.
            if (last) begin
                done_nxt = cur_oh;
                ptr_nxt  = (cur_ch == CH_W'(NUM_CH - 1)) ? '0 : cur_ch + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_turbo_pkt_dispatch.sv
// Bench for turbo_pkt_dispatch: vector table on a 2-lane/2-word instance, then
// directed and random traffic on the default instance against a packet model.
module tb_turbo_pkt_dispatch;
  localparam int BUS  = 534;
  localparam int NCH  = 4;
  localparam int PLEN = 25;

  logic clk_bus = 1'b0;
  always #5 clk_bus = ~clk_bus;

  // default-parameter instance
  logic           rst = 1'b1;
  logic [BUS-1:0] bus_data = '0;
  logic           bus_en = 1'b0;
  logic           bus_ready;
  logic [NCH-1:0] ch_mask = '1;
  logic [NCH-1:0] ch_ready = '1;
  logic [BUS-1:0] ch_data;
  logic [NCH-1:0] ch_en;
  logic [3:0]     cur_ch;
  logic           busy;
  logic [NCH-1:0] pkt_done;
  logic           err_drop;

  turbo_pkt_dispatch dut (
    .clk_bus(clk_bus), .rst(rst), .bus_data(bus_data), .bus_en(bus_en),
    .bus_ready(bus_ready), .ch_mask(ch_mask), .ch_ready(ch_ready),
    .ch_data(ch_data), .ch_en(ch_en), .cur_ch(cur_ch), .busy(busy),
    .pkt_done(pkt_done), .err_drop(err_drop)
  );

  // two lanes, two-word packets
  logic       rst1 = 1'b1, en1 = 1'b0, br1, busy1, err1;
  logic [7:0] data1 = '0, chdata1;
  logic [1:0] mask1 = 2'b11, rdy1 = 2'b11, chen1, done1;
  logic [0:0] cur1;

  turbo_pkt_dispatch #(.BUS(8), .NUM_CH(2), .PKT_LEN(2), .CH_W(1), .CNT_W(1)) dut1 (
    .clk_bus(clk_bus), .rst(rst1), .bus_data(data1), .bus_en(en1),
    .bus_ready(br1), .ch_mask(mask1), .ch_ready(rdy1),
    .ch_data(chdata1), .ch_en(chen1), .cur_ch(cur1), .busy(busy1),
    .pkt_done(done1), .err_drop(err1)
  );

  typedef struct packed {
    logic       rst;
    logic       en;
    logic [1:0] rdy;
    logic       br;
    logic [1:0] en_o;
    logic [1:0] done;
    logic       busy;
    logic       cur;
    logic       err;
  } vec_t;
  vec_t vecs[16];

  int checks = 0;
  int errors = 0;

  // packet-level model of the default instance
  bit             m_locked = 0;
  int             m_lane = 0, m_cnt = 0, m_ptr = 0;
  logic           e_br = 0, e_busy = 0, e_err = 0;
  logic [NCH-1:0] e_en = '0, e_done = '0;
  logic [3:0]     e_cur = '0;
  logic [BUS-1:0] e_data = '0;

  logic [BUS-1:0] exp_q[$];
  int             done_lanes[$];
  int             en_count[NCH];

  task automatic check(string name, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic check_data(string name, logic [BUS-1:0] got, logic [BUS-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [BUS-1:0] rand_word();
    logic [BUS-1:0] d = '0;
    for (int k = 0; k < (BUS + 31) / 32; k++) d = {d[BUS-33:0], 32'($urandom)};
    return d;
  endfunction

  // Predicts outputs after the coming edge from the inputs now applied.
  task automatic model_next();
    e_en   = '0;
    e_done = '0;
    if (rst) begin
      m_locked = 0; m_lane = 0; m_cnt = 0; m_ptr = 0;
      e_br = 0; e_busy = 0; e_err = 0; e_cur = '0; e_data = '0;
      return;
    end
    if (!m_locked) begin
      if (bus_en) e_err = 1'b1;
      e_br = 1'b0;
      for (int k = 0; k < NCH; k++) begin
        int c;
        c = (m_ptr + k) % NCH;
        if (ch_mask[c] && ch_ready[c]) begin
          m_locked = 1; m_lane = c; m_cnt = 0; e_br = 1'b1; e_cur = 4'(c);
          break;
        end
      end
    end else begin
      e_br = ch_ready[m_lane];
      if (bus_en) begin
        e_en[m_lane] = 1'b1;
        e_data = bus_data;
        m_cnt++;
        if (m_cnt == PLEN) begin
          e_done[m_lane] = 1'b1;
          m_cnt = 0;
          m_locked = 0;
          m_ptr = (m_lane + 1) % NCH;
          e_br = 1'b0;
        end
      end
    end
    e_busy = m_locked;
  endtask

  task automatic step();
    bit was_rst;
    was_rst = rst;
    if (!rst && m_locked && bus_en) exp_q.push_back(bus_data);
    model_next();
    @(posedge clk_bus);
    #1;
    check("ctrl", 64'({bus_ready, ch_en, cur_ch, busy, pkt_done, err_drop}),
          64'({e_br, e_en, e_cur, e_busy, e_done, e_err}));
    check_data("ch_data_hold", ch_data, e_data);
    if (was_rst) exp_q.delete();
    if (ch_en != '0) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL data_q got ch_en=%b with no word expected", ch_en);
      end else begin
        check_data("ch_data_sb", ch_data, exp_q.pop_front());
      end
    end
    for (int l = 0; l < NCH; l++) begin
      if (ch_en[l]) en_count[l]++;
      if (pkt_done[l]) done_lanes.push_back(l);
    end
  endtask

  task automatic clear_stats();
    done_lanes.delete();
    for (int l = 0; l < NCH; l++) en_count[l] = 0;
  endtask

  // Upstream that issues a word whenever bus_ready is high.
  task automatic run_follow(int n);
    repeat (n) begin
      bus_en   = bus_ready;
      bus_data = rand_word();
      step();
    end
    bus_en = 1'b0;
  endtask

  task automatic run_until_done(string name, int ndone, int budget);
    int cyc = 0;
    while (done_lanes.size() < ndone && cyc < budget) begin
      run_follow(1);
      cyc++;
    end
    check({name, "_timeout"}, 64'(done_lanes.size() >= ndone), 64'(1));
  endtask

  task automatic run_until_words(string name, int lane, int nwords, int budget);
    int cyc = 0;
    while (en_count[lane] < nwords && cyc < budget) begin
      run_follow(1);
      cyc++;
    end
    check({name, "_timeout"}, 64'(en_count[lane] >= nwords), 64'(1));
  endtask

  initial begin
    // rst en rdy | bus_ready ch_en pkt_done busy cur_ch err_drop
    vecs[0]  = 12'b1_0_11_0_00_00_0_0_0;
    vecs[1]  = 12'b0_0_11_1_00_00_1_0_0;
    vecs[2]  = 12'b0_1_11_1_01_00_1_0_0;
    vecs[3]  = 12'b0_1_11_0_01_01_0_0_0;
    vecs[4]  = 12'b0_0_11_1_00_00_1_1_0;
    vecs[5]  = 12'b0_1_11_1_10_00_1_1_0;
    vecs[6]  = 12'b0_1_11_0_10_10_0_1_0;
    vecs[7]  = 12'b0_0_11_1_00_00_1_0_0;
    vecs[8]  = 12'b0_1_11_1_01_00_1_0_0;
    vecs[9]  = 12'b0_1_11_0_01_01_0_0_0;
    vecs[10] = 12'b0_1_00_0_00_00_0_0_1;
    vecs[11] = 12'b0_0_10_1_00_00_1_1_1;
    vecs[12] = 12'b0_1_00_0_10_00_1_1_1;
    vecs[13] = 12'b0_1_00_0_10_10_0_1_1;
    vecs[14] = 12'b0_0_11_1_00_00_1_0_1;
    vecs[15] = 12'b1_0_11_0_00_00_0_0_0;
    clear_stats();

    for (int i = 0; i < 16; i++) begin
      rst1  = vecs[i].rst;
      en1   = vecs[i].en;
      rdy1  = vecs[i].rdy;
      data1 = 8'(i);
      @(posedge clk_bus);
      #1;
      check($sformatf("vec%0d", i), 64'({br1, chen1, cur1, busy1, done1, err1}),
            64'({vecs[i].br, vecs[i].en_o, vecs[i].cur, vecs[i].busy, vecs[i].done, vecs[i].err}));
    end

    // reset state of the default instance
    rst = 1'b1;
    step();
    step();
    check("rst_ctrl", 64'({bus_ready, ch_en, cur_ch, busy, pkt_done, err_drop}), 64'(0));
    check_data("rst_data", ch_data, '0);
    rst = 1'b0;

    // all lanes open: eight packets rotate 0..3 twice
    clear_stats();
    run_until_done("rr", 8, 400);
    for (int i = 0; i < 8; i++)
      check($sformatf("rr_lane%0d", i), 64'(i < done_lanes.size() ? done_lanes[i] : -1), 64'(i % NCH));
    for (int l = 0; l < NCH; l++) check($sformatf("rr_words%0d", l), 64'(en_count[l]), 64'(2 * PLEN));

    // lane 2 masked, lane 1 not ready: only 0 and 3 are used
    ch_mask  = 4'b1011;
    ch_ready = 4'b1101;
    clear_stats();
    run_until_done("mask", 4, 250);
    for (int i = 0; i < 4; i++)
      check($sformatf("mask_lane%0d", i), 64'(i < done_lanes.size() ? done_lanes[i] : -1), 64'((i % 2) * 3));
    check("mask_words1", 64'(en_count[1]), 64'(0));
    check("mask_words2", 64'(en_count[2]), 64'(0));

    // lane ready drops for five cycles mid-packet
    ch_mask  = '1;
    ch_ready = '1;
    clear_stats();
    run_until_words("stall", 0, 10, 50);
    ch_ready = 4'b1110;
    run_follow(1);
    check("stall_ready_low", 64'(bus_ready), 64'(0));
    run_follow(4);
    ch_ready = '1;
    run_until_done("stall", 1, 100);
    check("stall_words", 64'(en_count[0]), 64'(PKT_LEN_CHECK()));
    check("stall_dones", 64'(done_lanes.size()), 64'(1));

    // word offered in IDLE with nothing ready is dropped and flagged
    ch_ready = '0;
    clear_stats();
    bus_en = 1'b1;
    bus_data = rand_word();
    step();
    bus_en = 1'b0;
    step();
    step();
    check("drop_err", 64'(err_drop), 64'(1));
    check("drop_no_en", 64'(en_count[0] + en_count[1] + en_count[2] + en_count[3]), 64'(0));
    ch_ready = 4'b0100;
    step();
    check("drop_pick", 64'({cur_ch, bus_ready, busy}), 64'({4'd2, 1'b1, 1'b1}));

    // reset partway through a lane-1 packet
    ch_ready = '1;
    run_until_done("pre_rst", 1, 60);
    ch_mask = 4'b0010;
    clear_stats();
    run_until_words("mid_rst", 1, 10, 60);
    rst = 1'b1;
    step();
    check("mid_rst_ctrl", 64'({bus_ready, ch_en, cur_ch, busy, pkt_done, err_drop}), 64'(0));
    check_data("mid_rst_data", ch_data, '0);
    rst = 1'b0;
    ch_mask = '1;
    clear_stats();
    run_until_done("post_rst", 1, 60);
    check("post_rst_lane", 64'(done_lanes.size() > 0 ? done_lanes[0] : -1), 64'(0));
    check("post_rst_l1", 64'(en_count[1]), 64'(0));

    // single enabled lane is reused back to back
    ch_mask = 4'b0001;
    clear_stats();
    run_until_done("single", 2, 120);
    check("single_lanes", 64'(done_lanes.size() == 2 ? done_lanes[0] + done_lanes[1] : -1), 64'(0));
    check("single_words", 64'(en_count[0]), 64'(2 * PLEN));

    // random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      rst      = ($urandom_range(0, 299) == 0);
      ch_mask  = 4'($urandom_range(0, 15));
      for (int l = 0; l < NCH; l++) ch_ready[l] = ($urandom_range(0, 3) != 0);
      bus_en   = 1'($urandom_range(0, 1));
      bus_data = rand_word();
      step();
    end
    rst = 1'b0;
    bus_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  function automatic int PKT_LEN_CHECK();
    return PLEN;
  endfunction

endmodule
